// File: rtl/bolucu_pkg.sv
// Shared types and constants for the bolucu iterative RV32M divider.
package bolucu_pkg;

    localparam int XLEN = 32;
    localparam int ITER = 32;

    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        BOL_DIV  = 2'b00,
        BOL_DIVU = 2'b01,
        BOL_REM  = 2'b10,
        BOL_REMU = 2'b11
    } bol_op_e;

    typedef enum logic [1:0] {
        BOL_IDLE = 2'd0,
        BOL_CALC = 2'd1,
        BOL_FIX  = 2'd2,
        BOL_DONE = 2'd3
    } bol_state_e;

endpackage

// File: rtl/bolucu_cikarici.sv
// 33-bit subtractor a - b for the restoring step; Kogge-Stone carry prefix
// built from grey/black cells, carry-in of 1 folded into bit 0.
module bolucu_cikarici
    import bolucu_pkg::*;
(
    input  logic [XLEN:0]   i_a,
    input  logic [XLEN:0]   i_b,
    output logic [XLEN-1:0] o_diff,
    output logic            o_borrow
);

    localparam int W   = XLEN + 1;
    localparam int LVL = $clog2(W);

    function automatic logic grey_cell(input logic gh, input logic ph, input logic gl);
        return gh | (ph & gl);
    endfunction

    function automatic logic [1:0] black_cell(input logic gh, input logic ph,
                                              input logic gl, input logic pl);
        return {gh | (ph & gl), ph & pl};
    endfunction

    logic [XLEN-1:0] prop0;
    logic [W-1:0]    g_c, p_c, g_n, p_n;

    assign prop0 = i_a[XLEN-1:0] ^ ~i_b[XLEN-1:0];

    always_comb begin
        g_c    = i_a & ~i_b;
        p_c    = i_a ^ ~i_b;
        g_c[0] = g_c[0] | p_c[0];
        g_n    = g_c;
        p_n    = p_c;
        for (int k = 0; k < LVL; k++) begin
            g_n = g_c;
            p_n = p_c;
            for (int i = (1 << k); i < W; i++) begin
                // Nodes whose span already reaches bit 0 only need the generate term
                if (i < (2 << k)) begin
                    g_n[i] = grey_cell(g_c[i], p_c[i], g_c[i - (1 << k)]);
                end else begin
                    {g_n[i], p_n[i]} = black_cell(g_c[i], p_c[i],
                                                  g_c[i - (1 << k)], p_c[i - (1 << k)]);
                end
            end
            g_c = g_n;
            p_c = p_n;
        end
        o_diff   = prop0 ^ {g_c[XLEN-2:0], 1'b1};
        o_borrow = ~g_c[XLEN];
    end

endmodule

// File: rtl/bolucu.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit with valid/ready result handshake.
// Optional result reuse cache enabled by defining BOLUCU_SONUC_YENIDEN_EN.
//
// state    | meaning
// IDLE     | ready for a request
// CALC     | 32 restoring steps on operand magnitudes
// FIX      | sign correction, quotient/remainder select
// DONE     | result valid, held until consumer takes it
module bolucu
    import bolucu_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result
);

    localparam logic [4:0] CNT_LOAD = 5'(ITER - 1);

    bol_state_e      state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [1:0]      op_q, op_d;
    logic            sgn1_q, sgn1_d, sgn2_q, sgn2_d;
    logic [XLEN-1:0] quo_q, quo_d, dvs_q, dvs_d, rem_q, rem_d, res_q, res_d;
    logic            vld_q, vld_d, rdy_q, rdy_d;

    logic            accept, fast_hit, reuse_hit, sub_borrow;
    logic [XLEN-1:0] fast_res, reuse_res, q_fix, r_fix, sub_diff;
    logic [XLEN:0]   sub_a;

    assign accept = i_valid && (state_q == BOL_IDLE) && !i_flush;
    assign sub_a  = {rem_q, quo_q[XLEN-1]};
    assign q_fix  = (sgn1_q ^ sgn2_q) ? -quo_q : quo_q;
    assign r_fix  = sgn1_q ? -rem_q : rem_q;

    bolucu_cikarici u_cikarici (
        .i_a      (sub_a),
        .i_b      ({1'b0, dvs_q}),
        .o_diff   (sub_diff),
        .o_borrow (sub_borrow)
    );

    always_comb begin
        fast_hit = 1'b1;
        fast_res = '0;
        if (i_rs2 == '0) begin
            fast_res = i_op[1] ? i_rs1 : '1;
        end else if (!i_op[0] && (i_rs1 == XMIN) && (i_rs2 == '1)) begin
            fast_res = i_op[1] ? '0 : XMIN;
        end else if (reuse_hit) begin
            fast_res = reuse_res;
        end else begin
            fast_hit = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        sgn1_d  = sgn1_q;
        sgn2_d  = sgn2_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        res_d   = res_q;
        unique case (state_q)
            BOL_IDLE: begin
                if (accept) begin
                    op_d   = i_op;
                    sgn1_d = ~i_op[0] & i_rs1[XLEN-1];
                    sgn2_d = ~i_op[0] & i_rs2[XLEN-1];
                    quo_d  = sgn1_d ? -i_rs1 : i_rs1;
                    dvs_d  = sgn2_d ? -i_rs2 : i_rs2;
                    rem_d  = '0;
                    cnt_d  = CNT_LOAD;
                    if (fast_hit) begin
                        state_d = BOL_DONE;
                        res_d   = fast_res;
                    end else begin
                        state_d = BOL_CALC;
                    end
                end
            end
            BOL_CALC: begin
                quo_d = {quo_q[XLEN-2:0], ~sub_borrow};
                rem_d = sub_borrow ? sub_a[XLEN-1:0] : sub_diff;
                if (cnt_q == '0) begin
                    state_d = BOL_FIX;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            BOL_FIX: begin
                res_d   = op_q[1] ? r_fix : q_fix;
                state_d = BOL_DONE;
            end
            BOL_DONE: begin
                if (i_ready) begin
                    state_d = BOL_IDLE;
                end
            end
            default: state_d = BOL_IDLE;
        endcase
        if (i_flush) begin
            state_d = BOL_IDLE;
        end
        // Handshake outputs are flopped copies of the next state decode
        rdy_d = (state_d == BOL_IDLE);
        vld_d = (state_d == BOL_DONE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= BOL_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            sgn1_q  <= 1'b0;
            sgn2_q  <= 1'b0;
            quo_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            res_q   <= '0;
            vld_q   <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sgn1_q  <= sgn1_d;
            sgn2_q  <= sgn2_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            res_q   <= res_d;
            vld_q   <= vld_d;
            rdy_q   <= rdy_d;
        end
    end

    assign o_ready  = rdy_q;
    assign o_valid  = vld_q;
    assign o_result = res_q;

`ifdef BOLUCU_SONUC_YENIDEN_EN
    logic            ru_vld_q, ru_vld_d, ru_sgn_q, ru_sgn_d;
    logic [XLEN-1:0] ru_rs1_q, ru_rs1_d, ru_rs2_q, ru_rs2_d;
    logic [XLEN-1:0] ru_quo_q, ru_quo_d, ru_rem_q, ru_rem_d;
    logic [XLEN-1:0] tag_rs1_q, tag_rs1_d, tag_rs2_q, tag_rs2_d;

    always_comb begin
        ru_vld_d  = ru_vld_q;
        ru_sgn_d  = ru_sgn_q;
        ru_rs1_d  = ru_rs1_q;
        ru_rs2_d  = ru_rs2_q;
        ru_quo_d  = ru_quo_q;
        ru_rem_d  = ru_rem_q;
        tag_rs1_d = tag_rs1_q;
        tag_rs2_d = tag_rs2_q;
        if (accept) begin
            tag_rs1_d = i_rs1;
            tag_rs2_d = i_rs2;
        end
        // Both results are kept so a DIV can feed a following REM and vice versa
        if (state_q == BOL_FIX) begin
            ru_vld_d = 1'b1;
            ru_sgn_d = ~op_q[0];
            ru_rs1_d = tag_rs1_q;
            ru_rs2_d = tag_rs2_q;
            ru_quo_d = q_fix;
            ru_rem_d = r_fix;
        end
        if (i_flush) begin
            ru_vld_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ru_vld_q  <= 1'b0;
            ru_sgn_q  <= 1'b0;
            ru_rs1_q  <= '0;
            ru_rs2_q  <= '0;
            ru_quo_q  <= '0;
            ru_rem_q  <= '0;
            tag_rs1_q <= '0;
            tag_rs2_q <= '0;
        end else begin
            ru_vld_q  <= ru_vld_d;
            ru_sgn_q  <= ru_sgn_d;
            ru_rs1_q  <= ru_rs1_d;
            ru_rs2_q  <= ru_rs2_d;
            ru_quo_q  <= ru_quo_d;
            ru_rem_q  <= ru_rem_d;
            tag_rs1_q <= tag_rs1_d;
            tag_rs2_q <= tag_rs2_d;
        end
    end

    assign reuse_hit = ru_vld_q && (i_rs1 == ru_rs1_q) && (i_rs2 == ru_rs2_q)
                       && (ru_sgn_q == ~i_op[0]);
    assign reuse_res = i_op[1] ? ru_rem_q : ru_quo_q;
`else
    assign reuse_hit = 1'b0;
    assign reuse_res = '0;
`endif

endmodule

// File: tb/tb_bolucu.sv
// Self-checking bench for bolucu: reference divider model feeds a result queue.
module tb_bolucu;
    import bolucu_pkg::*;

`ifdef BOLUCU_SONUC_YENIDEN_EN
    localparam int RL = 1;
`else
    localparam int RL = 34;
`endif
    localparam int NL = 34;

    logic        i_clk = 1'b0;
    logic        i_rst_n, i_valid, i_flush, i_ready;
    logic [1:0]  i_op;
    logic [31:0] i_rs1, i_rs2;
    logic        o_ready, o_valid;
    logic [31:0] o_result;

    logic [31:0] exp_q[$];
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 i_clk = ~i_clk;

    bolucu dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_op     (i_op),
        .i_rs1    (i_rs1),
        .i_rs2    (i_rs2),
        .i_flush  (i_flush),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result)
    );

    function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : a;
            return op[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
        end
        return op[1] ? (a % b) : (a / b);
    endfunction

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_q.push_back(ref_res(op, a, b));
        i_op = op; i_rs1 = a; i_rs2 = b; i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat, output logic [31:0] res);
        lat = -1;
        res = 32'hxxxx_xxxx;
        for (int c = 1; c <= 60; c++) begin
            if (o_valid) begin
                lat = c;
                res = o_result;
                break;
            end
            @(posedge i_clk); #1;
        end
    endtask

    task automatic release_result();
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
    endtask

    task automatic pulse_flush();
        i_flush = 1'b1;
        @(posedge i_clk); #1;
        i_flush = 1'b0;
    endtask

    task automatic test_reset();
        n_chk++; if (o_ready !== 1'b1) $display("FAIL rst_ready: got %b required 1", o_ready); else n_pass++;
        n_chk++; if (o_valid !== 1'b0) $display("FAIL rst_valid: got %b required 0", o_valid); else n_pass++;
        n_chk++; if (o_result !== 32'd0) $display("FAIL rst_result: got %h required 0", o_result); else n_pass++;
    endtask

    task automatic test_unsigned();
        int lat; logic [31:0] res, exp;
        issue(BOL_DIVU, 32'd100, 32'd7);
        n_chk++; if (o_ready !== 1'b0) $display("FAIL calc_ready: got %b required 0", o_ready); else n_pass++;
        wait_result(lat, res); exp = exp_q.pop_front(); release_result();
        n_chk++; if (lat !== NL) $display("FAIL divu_lat: got %0d required %0d", lat, NL); else n_pass++;
        n_chk++; if (res !== exp) $display("FAIL divu_res: got %h required %h", res, exp); else n_pass++;
        issue(BOL_REMU, 32'd100, 32'd7);
        wait_result(lat, res); exp = exp_q.pop_front(); release_result();
        n_chk++; if (lat !== RL) $display("FAIL remu_lat: got %0d required %0d", lat, RL); else n_pass++;
        n_chk++; if (res !== exp) $display("FAIL remu_res: got %h required %h", res, exp); else n_pass++;
    endtask

    task automatic test_signed();
        int lat; logic [31:0] res, exp;
        issue(BOL_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_result(lat, res); exp = exp_q.pop_front(); release_result();
        n_chk++; if (lat !== NL) $display("FAIL div_neg_lat: got %0d required %0d", lat, NL); else n_pass++;
        n_chk++; if (res !== exp) $display("FAIL div_neg_res: got %h required %h", res, exp); else n_pass++;
        issue(BOL_REM, 32'hFFFF_FFF9, 32'd2);
        wait_result(lat, res); exp = exp_q.pop_front(); release_result();
        n_chk++; if (lat !== RL) $display("FAIL rem_neg_lat: got %0d required %0d", lat, RL); else n_pass++;
        n_chk++; if (res !== exp) $display("FAIL rem_neg_res: got %h required %h", res, exp); else n_pass++;
    endtask

    task automatic test_special();
        int lat; logic [31:0] res, exp;
        logic [1:0]  ops [4] = '{BOL_DIV, BOL_REMU, BOL_DIV, BOL_REM};
        logic [31:0] as  [4] = '{32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i]);
            wait_result(lat, res); exp = exp_q.pop_front(); release_result();
            n_chk++; if (lat !== 1) $display("FAIL special_lat[%0d]: got %0d required 1", i, lat); else n_pass++;
            n_chk++; if (res !== exp) $display("FAIL special_res[%0d]: got %h required %h", i, res, exp); else n_pass++;
        end
    endtask

    task automatic test_hold();
        int lat; logic [31:0] res, exp;
        issue(BOL_DIVU, 32'hFFFF_FFFF, 32'd1);
        wait_result(lat, res); exp = exp_q.pop_front();
        n_chk++; if (lat !== NL) $display("FAIL hold_lat: got %0d required %0d", lat, NL); else n_pass++;
        n_chk++; if (res !== exp) $display("FAIL hold_res: got %h required %h", res, exp); else n_pass++;
        for (int c = 0; c < 5; c++) begin
            @(posedge i_clk); #1;
            n_chk++; if (o_valid !== 1'b1) $display("FAIL hold_valid[%0d]: got %b required 1", c, o_valid); else n_pass++;
            n_chk++; if (o_result !== exp) $display("FAIL hold_data[%0d]: got %h required %h", c, o_result, exp); else n_pass++;
            n_chk++; if (o_ready !== 1'b0) $display("FAIL hold_ready[%0d]: got %b required 0", c, o_ready); else n_pass++;
        end
        release_result();
        n_chk++; if (o_ready !== 1'b1) $display("FAIL post_hs_ready: got %b required 1", o_ready); else n_pass++;
    endtask

    task automatic test_flush();
        int lat; logic [31:0] res, exp;
        bit seen = 1'b0;
        issue(BOL_DIVU, 32'h1234_5678, 32'h13);
        repeat (9) begin @(posedge i_clk); #1; end
        i_flush = 1'b1;
        @(posedge i_clk); #1;
        i_flush = 1'b0;
        void'(exp_q.pop_front());
        n_chk++; if (o_ready !== 1'b1) $display("FAIL flush_ready: got %b required 1", o_ready); else n_pass++;
        for (int c = 0; c < 40; c++) begin
            if (o_valid) seen = 1'b1;
            @(posedge i_clk); #1;
        end
        n_chk++; if (seen !== 1'b0) $display("FAIL flush_valid: got %b required 0", seen); else n_pass++;
        issue(BOL_DIVU, 32'd9, 32'd3);
        wait_result(lat, res); exp = exp_q.pop_front(); release_result();
        n_chk++; if (lat !== NL) $display("FAIL after_flush_lat: got %0d required %0d", lat, NL); else n_pass++;
        n_chk++; if (res !== exp) $display("FAIL after_flush_res: got %h required %h", res, exp); else n_pass++;
    endtask

    task automatic test_flush_vs_valid();
        bit seen = 1'b0;
        i_op = BOL_DIVU; i_rs1 = 32'd5; i_rs2 = 32'd1;
        i_valid = 1'b1; i_flush = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_flush = 1'b0;
        n_chk++; if (o_ready !== 1'b1) $display("FAIL fvv_ready: got %b required 1", o_ready); else n_pass++;
        for (int c = 0; c < 40; c++) begin
            if (o_valid) seen = 1'b1;
            @(posedge i_clk); #1;
        end
        n_chk++; if (seen !== 1'b0) $display("FAIL fvv_valid: got %b required 0", seen); else n_pass++;
    endtask

    task automatic test_reuse();
        int lat; logic [31:0] res, exp;
        logic [1:0] ops  [4] = '{BOL_DIV, BOL_REM, BOL_DIVU, BOL_REMU};
        int         lats [4] = '{NL, RL, NL, NL};
        pulse_flush();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) pulse_flush();
            issue(ops[i], 32'd1000, 32'd3);
            wait_result(lat, res); exp = exp_q.pop_front(); release_result();
            n_chk++; if (lat !== lats[i]) $display("FAIL reuse_lat[%0d]: got %0d required %0d", i, lat, lats[i]); else n_pass++;
            n_chk++; if (res !== exp) $display("FAIL reuse_res[%0d]: got %h required %h", i, res, exp); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int lat, elat; logic [31:0] res, exp, a, b; logic [1:0] op;
        for (int i = 0; i < 6; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 30));
            elat = (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : NL;
            issue(op, a, b);
            wait_result(lat, res); exp = exp_q.pop_front(); release_result();
            n_chk++; if (lat !== elat) $display("FAIL b2b_lat[%0d]: got %0d required %0d", i, lat, elat); else n_pass++;
            n_chk++; if (res !== exp) $display("FAIL b2b_res[%0d] op%0d %h/%h: got %h required %h", i, op, a, b, res, exp); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] res, exp;
        issue(BOL_DIVU, 32'd77, 32'd5);
        repeat (5) begin @(posedge i_clk); #1; end
        #2 i_rst_n = 1'b0;
        #1;
        void'(exp_q.pop_front());
        n_chk++; if (o_ready !== 1'b1) $display("FAIL midrst_ready: got %b required 1", o_ready); else n_pass++;
        n_chk++; if (o_valid !== 1'b0) $display("FAIL midrst_valid: got %b required 0", o_valid); else n_pass++;
        n_chk++; if (o_result !== 32'd0) $display("FAIL midrst_result: got %h required 0", o_result); else n_pass++;
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        issue(BOL_DIV, 32'd1000, 32'd3);
        wait_result(lat, res); exp = exp_q.pop_front(); release_result();
        n_chk++; if (lat !== NL) $display("FAIL after_rst_lat: got %0d required %0d", lat, NL); else n_pass++;
        n_chk++; if (res !== exp) $display("FAIL after_rst_res: got %h required %h", res, exp); else n_pass++;
    endtask

    initial begin
        i_rst_n = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b0;
        i_op = 2'b00; i_rs1 = 32'd0; i_rs2 = 32'd0;
        repeat (2) @(posedge i_clk);
        #1;
        test_reset();
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        test_unsigned();
        test_signed();
        test_special();
        test_hold();
        test_flush();
        test_flush_vs_valid();
        test_reuse();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
